// File: rtl/eu_operand_collector.sv
// Operand collector: pops one queue entry at a time, gathers both source
// operands from the register file or the result broadcast bus, and holds
// the instruction plus operands toward the ALU under valid/ready.

package eu_oc_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  dst_tag;
    logic [17:0] imm;
  } type_iqueue_entry;
endpackage

module eu_operand_collector
  import eu_oc_pkg::*;
#(
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  type_iqueue_entry      instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [TAG_WIDTH-1:0]  srca_tag_i,
  input  logic [TAG_WIDTH-1:0]  srcb_tag_i,
  input  logic                  srca_used_i,
  input  logic                  srcb_used_i,
  output logic [TAG_WIDTH-1:0]  rf_a_tag_o,
  output logic [TAG_WIDTH-1:0]  rf_b_tag_o,
  input  logic                  rf_a_rdy_i,
  input  logic                  rf_b_rdy_i,
  input  logic [DATA_WIDTH-1:0] rf_a_data_i,
  input  logic [DATA_WIDTH-1:0] rf_b_data_i,
  input  logic                  cdb_valid_i,
  input  logic [TAG_WIDTH-1:0]  cdb_tag_i,
  input  logic [DATA_WIDTH-1:0] cdb_data_i,
  input  logic                  flush_i,
  output type_iqueue_entry      exec_instr_o,
  output logic [DATA_WIDTH-1:0] exec_opa_o,
  output logic [DATA_WIDTH-1:0] exec_opb_o,
  output logic                  exec_valid_o,
  input  logic                  exec_ready_i
);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

  state_t                r_state;
  type_iqueue_entry      r_instr;
  logic [TAG_WIDTH-1:0]  r_tag_a, r_tag_b;
  logic                  r_rdy_a, r_rdy_b;
  logic [DATA_WIDTH-1:0] r_opa, r_opb;
  logic                  r_valid;

  logic                  w_collect, w_accept;
  logic [TAG_WIDTH-1:0]  w_tag_a, w_tag_b;
  logic                  w_used_a, w_used_b;
  logic                  w_rdy_a, w_rdy_b;
  logic [DATA_WIDTH-1:0] w_val_a, w_val_b;

  assign w_collect     = (r_state == COLLECT);
  // Pop when empty, or when the held instruction leaves this very cycle.
  assign instr_ready_o = ((r_state == IDLE) | ((r_state == ISSUE) & exec_ready_i))
                         & ~flush_i & ~reset;
  assign w_accept      = instr_valid_i & instr_ready_o;

  // While collecting, look up the held tags; otherwise the incoming entry's.
  // An unused operand was already marked ready on accept, so it counts as used here.
  assign w_tag_a    = w_collect ? r_tag_a : srca_tag_i;
  assign w_tag_b    = w_collect ? r_tag_b : srcb_tag_i;
  assign w_used_a   = w_collect | srca_used_i;
  assign w_used_b   = w_collect | srcb_used_i;
  assign rf_a_tag_o = w_tag_a;
  assign rf_b_tag_o = w_tag_b;

  // Resolve operand A: keep ready value, else unused->0, else CDB before RF.
  always_comb begin
    w_rdy_a = 1'b1;
    w_val_a = '0;
    if (w_collect && r_rdy_a)                        w_val_a = r_opa;
    else if (!w_used_a)                              w_val_a = '0;
    else if (cdb_valid_i && (cdb_tag_i == w_tag_a))  w_val_a = cdb_data_i;
    else if (rf_a_rdy_i)                             w_val_a = rf_a_data_i;
    else                                             w_rdy_a = 1'b0;
  end

  // Resolve operand B with the same priority.
  always_comb begin
    w_rdy_b = 1'b1;
    w_val_b = '0;
    if (w_collect && r_rdy_b)                        w_val_b = r_opb;
    else if (!w_used_b)                              w_val_b = '0;
    else if (cdb_valid_i && (cdb_tag_i == w_tag_b))  w_val_b = cdb_data_i;
    else if (rf_b_rdy_i)                             w_val_b = rf_b_data_i;
    else                                             w_rdy_b = 1'b0;
  end

  // FSM: accept/collect updates operand state; issue drains on exec_ready_i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_tag_a <= '0;
      r_tag_b <= '0;
      r_rdy_a <= 1'b0;
      r_rdy_b <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else if (w_accept || w_collect) begin
      if (w_accept) begin
        r_instr <= instr_i;
        r_tag_a <= srca_tag_i;
        r_tag_b <= srcb_tag_i;
      end
      r_rdy_a <= w_rdy_a;
      r_rdy_b <= w_rdy_b;
      r_opa   <= w_val_a;
      r_opb   <= w_val_b;
      if (w_rdy_a && w_rdy_b) begin
        r_state <= ISSUE;
        r_valid <= 1'b1;
      end else begin
        r_state <= COLLECT;
        r_valid <= 1'b0;
      end
    end else if ((r_state == ISSUE) && exec_ready_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end
  end

  assign exec_instr_o = r_instr;
  assign exec_opa_o   = r_opa;
  assign exec_opb_o   = r_opb;
  assign exec_valid_o = r_valid;

endmodule

// File: tb/tb_eu_operand_collector.sv
// Bench for eu_operand_collector: table of single-accept vectors, directed
// multi-cycle sequences, then randomized traffic against a transaction model.
module tb_eu_operand_collector;
  import eu_oc_pkg::*;
  localparam int TW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  type_iqueue_entry instr_i, exec_instr_o;
  logic instr_valid_i, instr_ready_o;
  logic [TW-1:0] srca_tag_i, srcb_tag_i, rf_a_tag_o, rf_b_tag_o, cdb_tag_i;
  logic srca_used_i, srcb_used_i, rf_a_rdy_i, rf_b_rdy_i;
  logic cdb_valid_i, flush_i, exec_valid_o, exec_ready_i;
  logic [DW-1:0] rf_a_data_i, rf_b_data_i, cdb_data_i, exec_opa_o, exec_opb_o;

  // Register file stand-in: direct drive for directed tests, array lookup for random.
  logic use_arr;
  logic d_a_rdy, d_b_rdy;
  logic [DW-1:0] d_a_dat, d_b_dat;
  logic          rf_rdy_arr [64];
  logic [DW-1:0] rf_dat_arr [64];
  assign rf_a_rdy_i  = use_arr ? rf_rdy_arr[rf_a_tag_o] : d_a_rdy;
  assign rf_b_rdy_i  = use_arr ? rf_rdy_arr[rf_b_tag_o] : d_b_rdy;
  assign rf_a_data_i = use_arr ? rf_dat_arr[rf_a_tag_o] : d_a_dat;
  assign rf_b_data_i = use_arr ? rf_dat_arr[rf_b_tag_o] : d_b_dat;

  eu_operand_collector #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .srca_tag_i(srca_tag_i), .srcb_tag_i(srcb_tag_i),
    .srca_used_i(srca_used_i), .srcb_used_i(srcb_used_i),
    .rf_a_tag_o(rf_a_tag_o), .rf_b_tag_o(rf_b_tag_o),
    .rf_a_rdy_i(rf_a_rdy_i), .rf_b_rdy_i(rf_b_rdy_i),
    .rf_a_data_i(rf_a_data_i), .rf_b_data_i(rf_b_data_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .flush_i(flush_i), .exec_instr_o(exec_instr_o), .exec_opa_o(exec_opa_o),
    .exec_opb_o(exec_opb_o), .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: at most one held instruction with per-operand knowledge.
  logic             m_have;
  type_iqueue_entry m_instr;
  logic [TW-1:0]    m_tag   [2];
  logic             m_known [2];
  logic [DW-1:0]    m_val   [2];

  function automatic logic rf_rdy(input int idx, input logic [TW-1:0] tag);
    if (use_arr) return rf_rdy_arr[tag];
    return (idx == 0) ? d_a_rdy : d_b_rdy;
  endfunction

  function automatic logic [DW-1:0] rf_dat(input int idx, input logic [TW-1:0] tag);
    if (use_arr) return rf_dat_arr[tag];
    return (idx == 0) ? d_a_dat : d_b_dat;
  endfunction

  function automatic void res(input logic used, input logic [TW-1:0] tag, input int idx,
                              output logic k, output logic [DW-1:0] v);
    k = 1'b1;
    v = '0;
    if (!used)                                     v = '0;
    else if (cdb_valid_i && (cdb_tag_i == tag))    v = cdb_data_i;
    else if (rf_rdy(idx, tag))                     v = rf_dat(idx, tag);
    else                                           k = 1'b0;
  endfunction

  // Check outputs against the model, then advance model across the next rising edge.
  task automatic step();
    logic             n_have, mv, retire;
    type_iqueue_entry n_instr;
    logic [TW-1:0]    n_tag   [2];
    logic             n_known [2];
    logic [DW-1:0]    n_val   [2];
    #1;
    mv = m_have && m_known[0] && m_known[1];
    chk("instr_ready", instr_ready_o, (!m_have || (mv && exec_ready_i)) && !flush_i);
    chk("exec_valid", exec_valid_o, mv);
    chk("rf_a_tag", rf_a_tag_o, (m_have && !mv) ? m_tag[0] : srca_tag_i);
    chk("rf_b_tag", rf_b_tag_o, (m_have && !mv) ? m_tag[1] : srcb_tag_i);
    if (mv) begin
      chk("exec_instr", exec_instr_o, m_instr);
      chk("exec_opa", exec_opa_o, m_val[0]);
      chk("exec_opb", exec_opb_o, m_val[1]);
    end
    n_have = m_have; n_instr = m_instr; n_tag = m_tag; n_known = m_known; n_val = m_val;
    retire = mv && exec_ready_i;
    if (flush_i) n_have = 1'b0;
    else if ((!m_have || retire) && instr_valid_i) begin
      n_have = 1'b1; n_instr = instr_i;
      n_tag[0] = srca_tag_i; n_tag[1] = srcb_tag_i;
      res(srca_used_i, srca_tag_i, 0, n_known[0], n_val[0]);
      res(srcb_used_i, srcb_tag_i, 1, n_known[1], n_val[1]);
    end else if (retire) n_have = 1'b0;
    else if (m_have) begin
      for (int i = 0; i < 2; i++)
        if (!m_known[i]) res(1'b1, m_tag[i], i, n_known[i], n_val[i]);
    end
    @(posedge clk);
    m_have = n_have; m_instr = n_instr; m_tag = n_tag; m_known = n_known; m_val = n_val;
  endtask

  task automatic idle();
    instr_valid_i = 1'b0; cdb_valid_i = 1'b0; flush_i = 1'b0; exec_ready_i = 1'b0;
    d_a_rdy = 1'b0; d_b_rdy = 1'b0; cdb_tag_i = '0; cdb_data_i = '0;
  endtask

  typedef struct {
    logic [TW-1:0] at, bt;
    logic          ua, ub, ar, br, cv;
    logic [DW-1:0] ad, bd;
    logic [TW-1:0] ct;
    logic [DW-1:0] cd;
    logic          ev;
    logic [DW-1:0] ea, eb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{at:5,  bt:6,  ua:1, ub:1, ar:1, br:1, cv:0, ad:32'h11, bd:32'h22, ct:0,  cd:0,          ev:1, ea:32'h11,   eb:32'h22};
    tbl[1] = '{at:7,  bt:8,  ua:1, ub:0, ar:1, br:0, cv:1, ad:32'h1,  bd:32'h0,  ct:7,  cd:32'hBEEF,   ev:1, ea:32'hBEEF, eb:32'h0};
    tbl[2] = '{at:1,  bt:2,  ua:0, ub:0, ar:0, br:0, cv:0, ad:32'h5,  bd:32'h6,  ct:0,  cd:0,          ev:1, ea:32'h0,    eb:32'h0};
    tbl[3] = '{at:3,  bt:4,  ua:1, ub:1, ar:1, br:0, cv:0, ad:32'h33, bd:32'h44, ct:0,  cd:0,          ev:0, ea:32'h0,    eb:32'h0};
    tbl[4] = '{at:10, bt:11, ua:1, ub:1, ar:1, br:0, cv:1, ad:32'hAA, bd:32'h0,  ct:11, cd:32'hC0DE,   ev:1, ea:32'hAA,   eb:32'hC0DE};
    tbl[5] = '{at:12, bt:13, ua:1, ub:0, ar:0, br:0, cv:1, ad:32'h0,  bd:32'h0,  ct:14, cd:32'h1234,   ev:0, ea:32'h0,    eb:32'h0};
    tbl[6] = '{at:20, bt:20, ua:1, ub:1, ar:1, br:1, cv:1, ad:32'h7,  bd:32'h8,  ct:20, cd:32'hFACE,   ev:1, ea:32'hFACE, eb:32'hFACE};
    tbl[7] = '{at:21, bt:22, ua:1, ub:0, ar:0, br:0, cv:0, ad:32'h0,  bd:32'h0,  ct:21, cd:32'h9999,   ev:0, ea:32'h0,    eb:32'h0};

    for (int i = 0; i < 64; i++) begin rf_rdy_arr[i] = 1'b0; rf_dat_arr[i] = '0; end
    use_arr = 1'b0; d_a_dat = '0; d_b_dat = '0;
    instr_i = '0; srca_tag_i = '0; srcb_tag_i = '0; srca_used_i = 1'b0; srcb_used_i = 1'b0;
    idle();
    m_have = 1'b0; m_instr = '0;
    for (int i = 0; i < 2; i++) begin m_tag[i] = '0; m_known[i] = 1'b0; m_val[i] = '0; end

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", exec_valid_o, 1'b0);
    chk("rst_ready", instr_ready_o, 1'b1);
    chk("rst_instr", exec_instr_o, 32'h0);
    chk("rst_opa", exec_opa_o, 32'h0);
    chk("rst_opb", exec_opb_o, 32'h0);
    step();

    // Table: one accept from IDLE, check next cycle, flush back to IDLE
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      instr_valid_i = 1'b1; instr_i = 32'h1000_0000 + i;
      srca_tag_i = tbl[i].at; srcb_tag_i = tbl[i].bt;
      srca_used_i = tbl[i].ua; srcb_used_i = tbl[i].ub;
      d_a_rdy = tbl[i].ar; d_b_rdy = tbl[i].br; d_a_dat = tbl[i].ad; d_b_dat = tbl[i].bd;
      cdb_valid_i = tbl[i].cv; cdb_tag_i = tbl[i].ct; cdb_data_i = tbl[i].cd;
      step();
      @(negedge clk); idle(); #1;
      chk($sformatf("tbl%0d_valid", i), exec_valid_o, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_opa", i), exec_opa_o, tbl[i].ea);
        chk($sformatf("tbl%0d_opb", i), exec_opb_o, tbl[i].eb);
      end
      step();
      @(negedge clk); idle(); flush_i = 1'b1; step();
    end

    // CDB wake-up three cycles after accept
    @(negedge clk); idle();
    instr_valid_i = 1'b1; instr_i = 32'hA0A0_0001;
    srca_tag_i = 9; srca_used_i = 1'b1; srcb_used_i = 1'b0;
    step();
    @(negedge clk); idle(); #1; chk("cdb_wait1", exec_valid_o, 1'b0); step();
    @(negedge clk); idle(); #1; chk("cdb_wait2", exec_valid_o, 1'b0); step();
    @(negedge clk); idle(); cdb_valid_i = 1'b1; cdb_tag_i = 9; cdb_data_i = 32'hDEAD; step();
    @(negedge clk); idle(); #1;
    chk("cdb_valid", exec_valid_o, 1'b1);
    chk("cdb_opa", exec_opa_o, 32'hDEAD);
    step();

    // ALU stall for five cycles, then back-to-back pop
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle(); #1;
      chk("stall_valid", exec_valid_o, 1'b1);
      chk("stall_opa", exec_opa_o, 32'hDEAD);
      chk("stall_ready", instr_ready_o, 1'b0);
      step();
    end
    @(negedge clk); idle();
    exec_ready_i = 1'b1; instr_valid_i = 1'b1; instr_i = 32'h5555_0002;
    srca_tag_i = 3; srcb_tag_i = 4; srca_used_i = 1'b1; srcb_used_i = 1'b1;
    d_a_rdy = 1'b1; d_b_rdy = 1'b1; d_a_dat = 32'h33; d_b_dat = 32'h44;
    #1; chk("b2b_pop", instr_ready_o, 1'b1);
    step();
    @(negedge clk); idle(); #1;
    chk("b2b_valid", exec_valid_o, 1'b1);
    chk("b2b_instr", exec_instr_o, 32'h5555_0002);
    chk("b2b_opa", exec_opa_o, 32'h33);
    chk("b2b_opb", exec_opb_o, 32'h44);
    step();

    // Flush beats exec_ready_i in ISSUE
    @(negedge clk); idle(); exec_ready_i = 1'b1; flush_i = 1'b1;
    #1; chk("flush_nopop", instr_ready_o, 1'b0);
    step();
    @(negedge clk); idle(); #1; chk("flush_iss_valid", exec_valid_o, 1'b0); step();

    // Flush during COLLECT, later matching broadcast must not revive it
    @(negedge clk); idle();
    instr_valid_i = 1'b1; instr_i = 32'h7777_0003;
    srca_tag_i = 12; srca_used_i = 1'b1; srcb_used_i = 1'b0;
    step();
    @(negedge clk); idle(); flush_i = 1'b1; step();
    @(negedge clk); idle(); cdb_valid_i = 1'b1; cdb_tag_i = 12; cdb_data_i = 32'hBEEF; step();
    @(negedge clk); idle(); #1; chk("flushc_valid1", exec_valid_o, 1'b0); step();
    @(negedge clk); idle(); #1; chk("flushc_valid2", exec_valid_o, 1'b0); step();

    // Asynchronous reset mid-ISSUE
    @(negedge clk); idle();
    instr_valid_i = 1'b1; instr_i = 32'h8888_0004;
    srca_used_i = 1'b0; srcb_used_i = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", exec_valid_o, 1'b0);
    chk("arst_instr", exec_instr_o, 32'h0);
    chk("arst_opa", exec_opa_o, 32'h0);
    m_have = 1'b0;
    idle();
    @(negedge clk); reset = 1'b0; #1;
    chk("arst_ready", instr_ready_o, 1'b1);
    chk("arst_idle", exec_valid_o, 1'b0);
    step();

    // Randomized traffic against the model
    use_arr = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      for (int t = 0; t < 8; t++) begin
        rf_rdy_arr[t] = ($urandom_range(3) == 0);
        rf_dat_arr[t] = $urandom;
      end
      instr_valid_i = $urandom_range(1);
      instr_i       = $urandom;
      srca_tag_i    = TW'($urandom_range(7));
      srcb_tag_i    = TW'($urandom_range(7));
      srca_used_i   = ($urandom_range(4) != 0);
      srcb_used_i   = ($urandom_range(4) != 0);
      cdb_valid_i   = $urandom_range(1);
      cdb_tag_i     = TW'($urandom_range(7));
      cdb_data_i    = $urandom;
      flush_i       = ($urandom_range(19) == 0);
      exec_ready_i  = ($urandom_range(4) < 3);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
